count_to_27mhz_conv: RTL and testbench
======================================

# count_to_27mhz_conv

Sequential converter from a 50 MHz-domain count to the equivalent 27 MHz-domain count, computing `count_on_27MHz = count_on_50MHz * 27 / 50`. It feeds speed and period values entered against the 50 MHz display/UI timebase back into the 27 MHz audio-rate counters. The block uses a multi-cycle restoring divider with a start/busy/done handshake, so no wide combinational divide sits on the 50 MHz path.

## Interface
Parameters:
- `WIDTH`, 32: width of the input and result counts.

Ports:
- `clk`: in, 1. System clock, posedge.
- `rst_n`: in, 1. Asynchronous, active-low reset.
- `count_on_50MHz`: in, `WIDTH`. Count to convert. Sampled only when a start is accepted.
- `start`: in, 1. Request a conversion. Level-sampled; accepted only in IDLE.
- `busy`: out, 1. High while a conversion is in progress.
- `done`: out, 1. One-cycle pulse when the result updates.
- `count_on_27MHz`: out, `WIDTH`. Last completed result. Holds its value between conversions.

## Operation
- Arithmetic:
  - Product P = x*27 is formed as (x<<4)+(x<<3)+(x<<1)+x, `WIDTH`+5 = 37 bits. No multiplier is used.
  - Quotient Q = P/50, truncated.
  - Q never exceeds 2^32-1 because 27/50 < 1, so there is no overflow output.
- States: IDLE, DIV, DONE.
- IDLE:
  - If `start`=1 at an edge: register the dividend P and clear the remainder (38 bits, one guard bit).
  - Load bit counter = 37, set `busy`, go to DIV.
- DIV, one quotient bit per cycle, MSB first:
  - rem = {rem, next dividend bit}.
  - If rem ≥ 50: subtract 50 and shift a 1 into the quotient; otherwise shift in a 0.
  - Decrement the counter. When the counter reaches 0, go to DONE.
- DONE: register the low `WIDTH` bits of the quotient into `count_on_27MHz`, pulse `done`, clear `busy`, return to IDLE.
- Boundary conditions:
  - `start` while busy: ignored, not queued. `count_on_50MHz` changes while busy have no effect on the running conversion.
  - `start` held high: one conversion runs per IDLE visit, i.e. back-to-back conversions.
  - Reset mid-operation: state goes to IDLE immediately. All internal registers and outputs clear. The partial result is discarded.
  - Input 0: result 0, full latency (no early exit).

## Timing
- Reset values:
  - `busy`=0, `done`=0, `count_on_27MHz`=0.
  - State IDLE; quotient, remainder and counter all 0.
- `start` accepted at edge k: `busy` is high from after edge k.
- DIV occupies edges k+1 through k+37.
- DONE is entered after edge k+37. At edge k+38:
  - `count_on_27MHz` updates;
  - `done` is high for exactly one cycle (k+38 to k+39);
  - `busy` falls.
- Start-to-result latency is 38 cycles. The next start can be accepted at edge k+39, giving a throughput of one conversion per 39 cycles.
- `done` and `busy` are never high in the same cycle.

## Configuration
- `ROUND_NEAREST_EN`:
  - Defined: the dividend is P+25, giving round-half-up to nearest.
  - Undefined: the dividend is P, giving truncation.
- The dividend stays within 37 bits in both cases (max 115964116990 < 2^37).
- Latency and handshake are identical with and without the macro.

## Structure
- Shared package `ipod_clk_pkg`:
  - `CLK_50MHZ_RATIO`=50, `CLK_27MHZ_RATIO`=27;
  - `COUNT_W`=32;
  - the conv state enum (IDLE/DIV/DONE).
- The ×27 shift-add and the top FSM/handshake live in the top module.
- One sub-module, `restoring_div`: generic iterative restoring divider by a constant, with load, step and ready signals, parameterised on dividend width and divisor.

## Test plan
- Reset, then `start` with x=50 -> `done` pulse 38 cycles after the start edge; `count_on_27MHz`=27. With x=100 -> 54.
- x=1 -> result 0 with the macro undefined; 1 with `ROUND_NEAREST_EN`. x=0 -> 0 in both builds after the full 38-cycle latency.
- x=0xFFFFFFFF -> 2319282339 (0x8A3D70A3) in both builds.
- x=50 started, then `start` pulsed with x=100 at cycle 10 -> exactly one `done`, result 27. `busy` is continuous for 38 cycles.
- `rst_n` low at cycle 20 of a conversion -> `busy`=0, `done`=0, result=0 immediately. No `done` follows. A new `start` with x=50 then gives 27.
- `start` held high with x=50 -> a `done` every 39 cycles. `done` and `busy` are never both high.

Source files
------------

// File: rtl/ipod_clk_pkg.sv
// Shared clock-domain constants and the 50->27 MHz converter state encoding.
package ipod_clk_pkg;

  localparam int unsigned CLK_50MHZ_RATIO = 50;
  localparam int unsigned CLK_27MHZ_RATIO = 27;
  localparam int unsigned COUNT_W         = 32;

  typedef enum logic [1:0] {
    CONV_IDLE = 2'd0,
    CONV_DIV  = 2'd1,
    CONV_DONE = 2'd2
  } conv_state_e;

endpackage

// File: rtl/restoring_div.sv
// Iterative restoring divider by a constant: one quotient bit per step, MSB first.
// load_i captures a new dividend and arms the bit counter; step_i advances one bit.
// ready_c is high when no bits remain; last_c flags the step that finishes the divide.
module restoring_div #(
  parameter int unsigned DVD_W   = 37,
  parameter int unsigned QUO_W   = 32,
  parameter int unsigned DIVISOR = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic             step_i,
  output logic [QUO_W-1:0] quotient_o,
  output logic             ready_c,
  output logic             last_c
);

  localparam int unsigned REM_W = DVD_W + 1;
  localparam int unsigned SH_W  = REM_W + 1;
  localparam int unsigned CNT_W = $clog2(DVD_W + 1);

  logic [DVD_W-1:0] dvd_q, dvd_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [SH_W-1:0]  rem_shift;
  logic [QUO_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load or trial-subtract the divisor from the shifted partial remainder.
  always_comb begin
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    rem_shift = {rem_q, dvd_q[DVD_W-1]};
    if (load_i) begin
      dvd_d = dividend_i;
      rem_d = '0;
      quo_d = '0;
      cnt_d = CNT_W'(DVD_W);
    end else if (step_i && (cnt_q != '0)) begin
      dvd_d = dvd_q << 1;
      cnt_d = cnt_q - CNT_W'(1);
      if (rem_shift >= SH_W'(DIVISOR)) begin
        rem_d = REM_W'(rem_shift - SH_W'(DIVISOR));
        quo_d = {quo_q[QUO_W-2:0], 1'b1};
      end else begin
        rem_d = REM_W'(rem_shift);
        quo_d = {quo_q[QUO_W-2:0], 1'b0};
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else begin
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient_o = quo_q;
  assign ready_c    = (cnt_q == '0);
  assign last_c     = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/count_to_27mhz_conv.sv
// Converts a 50 MHz-domain count to the 27 MHz domain: x*27/50 via shift-add
// and a 37-step restoring divide, with a start/busy/done handshake.
// Optional macro ROUND_NEAREST_EN: divide P+25 instead of P (round half up).
module count_to_27mhz_conv
  import ipod_clk_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] count_on_50MHz,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count_on_27MHz
);

  localparam int unsigned DVD_W = WIDTH + 5;

  conv_state_e      state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [DVD_W-1:0] x_ext;
  logic [DVD_W-1:0] product;
  logic [DVD_W-1:0] dividend;
  logic [WIDTH-1:0] quotient;
  logic             div_load;
  logic             div_step;
  logic             div_ready_c;
  logic             div_last_c;

  // x*27 as x*16 + x*8 + x*2 + x; the 5 extra bits hold the full product.
  assign x_ext   = DVD_W'(count_on_50MHz);
  assign product = (x_ext << 4) + (x_ext << 3) + (x_ext << 1) + x_ext;

`ifdef ROUND_NEAREST_EN
  assign dividend = product + DVD_W'(CLK_50MHZ_RATIO / 2);
`else
  assign dividend = product;
`endif

  restoring_div #(
    .DVD_W   (DVD_W),
    .QUO_W   (WIDTH),
    .DIVISOR (CLK_50MHZ_RATIO)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (div_load),
    .dividend_i (dividend),
    .step_i     (div_step),
    .quotient_o (quotient),
    .ready_c    (div_ready_c),
    .last_c     (div_last_c)
  );

  // Next-state and handshake outputs.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      CONV_IDLE: begin
        if (start && div_ready_c) begin
          div_load = 1'b1;
          busy_d   = 1'b1;
          state_d  = CONV_DIV;
        end
      end
      CONV_DIV: begin
        div_step = 1'b1;
        if (div_last_c) begin
          state_d = CONV_DONE;
        end
      end
      CONV_DONE: begin
        result_d = quotient;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = CONV_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = CONV_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CONV_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign count_on_27MHz = result_q;

endmodule

// File: tb/tb_count_to_27mhz_conv.sv
// Scoreboard bench for count_to_27mhz_conv: driver predicts accepted starts and
// pushes expected results; monitor checks done timing, result, busy each cycle.
module tb_count_to_27mhz_conv;

  localparam int unsigned LAT    = 38;
  localparam int unsigned PERIOD = 39;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] res;

  always #5 clk = ~clk;

  count_to_27mhz_conv #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .count_on_50MHz (x_in),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .count_on_27MHz (res)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] exp;
    int          k;
  } txn_t;

  txn_t        sb[$];
  int          cyc = 0;
  int          next_free = 0;
  logic [31:0] last_res = '0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: count * 27 / 50 in wide arithmetic.
  function automatic logic [31:0] ref_conv(input logic [31:0] x);
    longint unsigned p;
    p = longint'(x) * 27;
`ifdef ROUND_NEAREST_EN
    p = p + 25;
`endif
    return 32'(p / 50);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // One cycle of stimulus; a start is predicted accepted only when the converter is free.
  task automatic drive(input logic [31:0] x, input bit s);
    txn_t t;
    @(negedge clk);
    x_in  = x;
    start = s;
    if (s && rst_n && (cyc + 1 >= next_free)) begin
      t.x   = x;
      t.exp = ref_conv(x);
      t.k   = cyc + 1;
      sb.push_back(t);
      next_free = cyc + 1 + PERIOD;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive($urandom, 1'b0);
  endtask

  task automatic convert(input logic [31:0] x);
    drive(x, 1'b1);
    idle(PERIOD + 3);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    sb.delete();
    next_free = 0;
    last_res  = '0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_x();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 120));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compares DUT against the scoreboard once per cycle, away from the edge.
  initial begin
    txn_t t;
    logic exp_busy;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", res, 32'd0);
      end else begin
        exp_busy = (sb.size() > 0) && (sb[0].k <= cyc) && (cyc < sb[0].k + int'(LAT));
        if (done) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
          end else begin
            t = sb.pop_front();
            check("done_cycle", 32'(cyc), 32'(t.k + int'(LAT)));
            last_res = t.exp;
            check("result", res, t.exp);
          end
        end else if ((sb.size() > 0) && (cyc >= sb[0].k + int'(LAT))) begin
          tests++;
          fails++;
          $display("FAIL missing_done: got done=0 expected done=1 (cycle %0d)", cyc);
          t = sb.pop_front();
          last_res = t.exp;
        end else begin
          check("result_hold", res, last_res);
        end
        check("busy", 32'(busy), 32'(exp_busy));
        check("done_busy_excl", 32'(done && busy), 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);
    idle(2);

    convert(32'd50);
    convert(32'd100);
    convert(32'd1);
    convert(32'd0);
    convert(32'hFFFF_FFFF);

    // Start pulsed while busy is ignored; input changes mid-divide have no effect.
    drive(32'd50, 1'b1);
    idle(9);
    drive(32'd100, 1'b1);
    idle(PERIOD);

    // Reset in the middle of a conversion discards it.
    drive(32'd50, 1'b1);
    idle(19);
    do_reset(2);
    idle(PERIOD + 5);
    convert(32'd50);

    // Start held high: back-to-back conversions.
    repeat (PERIOD * 4) drive(32'd50, 1'b1);
    idle(PERIOD + 3);

    // Randomised traffic with frequent stray starts.
    repeat (3000) drive(rand_x(), ($urandom_range(0, 3) == 0));
    idle(PERIOD + 5);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
